// File: rtl/rr_arbiter16.sv
// rr_arbiter16: sixteen-requester round-robin arbiter with done handshake and hold timeout
module rr_arbiter16 #(
    parameter logic [7:0] MAX_HOLD = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout,
    output logic [7:0]  status
);
    typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;
    state_t      state_q;
    logic [3:0]  ptr_q;
    logic [3:0]  gnt_id_q;
    logic [7:0]  hold_cnt_q;
    logic [15:0] gnt_q;
    logic        gnt_valid_q;
    logic        timeout_q;
    logic [3:0]  win_id_d;
    logic        win_found_d;
    logic        release_d;
    logic        expire_d;
    // search ptr+1 .. ptr+16 (wrapping); walking downward lets the nearest hit win
    always_comb begin
        win_found_d = 1'b0;
        win_id_d    = 4'd0;
        for (int i = 16; i >= 1; i--) begin
            if (req[ptr_q + 4'(i)]) begin
                win_found_d = 1'b1;
                win_id_d    = ptr_q + 4'(i);
            end
        end
    end
    assign release_d = done | ~req[gnt_id_q];
    assign expire_d  = hold_cnt_q == MAX_HOLD - 8'd1;
    // arbitration FSM with registered grant outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 4'd15;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 16'd0;
            gnt_id_q    <= 4'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gnt_q       <= win_found_d ? 16'd1 << win_id_d : 16'd0;
                    gnt_id_q    <= win_found_d ? win_id_d : 4'd0;
                    gnt_valid_q <= win_found_d;
                    hold_cnt_q  <= 8'd0;
                    state_q     <= win_found_d ? GRANT : IDLE;
                end
                GRANT: begin
                    hold_cnt_q <= (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
                    if (release_d || expire_d) begin
                        gnt_q       <= 16'd0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_id_q;
                        timeout_q   <= ~release_d;
                        state_q     <= RECOVER;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign status    = gnt_valid_q ? {4'b0, gnt_id_q} : 8'hF0;
endmodule
